// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared constants, state encoding and digit check for the sequential BCD-to-binary converter.
package bcd_to_bin_seq_pkg;

  localparam int DIGIT_W     = 4;
  localparam int CORR_THRESH = 8;
  localparam int CORR_CONST  = 3;
  localparam int DIGIT_MAX   = 9;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] digit);
    return digit > DIGIT_W'(DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/busy/done handshake and data bus between the digit-entry logic and the converter.
interface bcd_to_bin_seq_if
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                        start;
  logic [DIGIT_W*DIGITS-1:0]   bcd_in;
  logic                        busy;
  logic                        done;
  logic                        err;
  logic [BIN_W-1:0]            bin_out;

  modport master (
    output start, bcd_in,
    input  busy, done, err, bin_out
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, err, bin_out
  );
endinterface

// File: rtl/bcd_to_bin_seq_three_subtractor.sv
// Reverse double-dabble correction cell: a shifted BCD field of 8..15 loses 3, anything else passes through.
module three_subtractor
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] field,
  output logic [DIGIT_W-1:0] fixed
);

  assign fixed = (field >= DIGIT_W'(CORR_THRESH)) ? field - DIGIT_W'(CORR_CONST) : field;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one right shift plus per-digit subtract-3 correction per clock.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
)(
  input  logic              clk,
  input  logic              reset,
  bcd_to_bin_seq_if.slave   bus
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state_reg;
  logic [SR_W-1:0]    sr_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               err_reg;
  logic [BIN_W-1:0]   bin_reg;

  logic [SR_W-1:0]    shifted;
  logic [SR_W-1:0]    corrected;
  logic [BCD_W-1:0]   corr_hi;
  logic [DIGITS-1:0]  bad_digit;

  assign shifted = sr_reg >> 1;

  // Each digit field is corrected on its own; no borrow crosses a digit boundary.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      three_subtractor u_sub (
        .field (shifted[BIN_W + DIGIT_W*gi +: DIGIT_W]),
        .fixed (corr_hi[DIGIT_W*gi +: DIGIT_W])
      );
      assign bad_digit[gi] = digit_invalid(bus.bcd_in[DIGIT_W*gi +: DIGIT_W]);
    end
  endgenerate

  assign corrected = {corr_hi, shifted[BIN_W-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      bin_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            if (|bad_digit) begin
              // Rejected input finishes immediately without entering CONV.
              err_reg  <= 1'b1;
              bin_reg  <= '0;
              done_reg <= 1'b1;
            end else begin
              sr_reg    <= {bus.bcd_in, {BIN_W{1'b0}}};
              cnt_reg   <= '0;
              busy_reg  <= 1'b1;
              err_reg   <= 1'b0;
              state_reg <= CONV;
            end
          end
        end
        CONV: begin
          sr_reg  <= corrected;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(BIN_W - 1)) begin
            bin_reg   <= corrected[BIN_W-1:0];
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.err     = err_reg;
  assign bus.bin_out = bin_reg;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: decimal reference model, directed handshake cases, random and full sweep.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int BCD_W  = 4 * DIGITS;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Decimal value of the digit string; any digit above 9 means error with a zero result.
  function automatic exp_t ref_model(input logic [BCD_W-1:0] bcd);
    exp_t r;
    int   val;
    int   dig;
    val   = 0;
    r.err = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      dig = int'((bcd >> (4 * d)) & 12'hF);
      if (dig > 9) r.err = 1'b1;
      val = val * 10 + dig;
    end
    r.bin = r.err ? '0 : BIN_W'(val);
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_done: got done=1 bin_out=%0d expected no done", bus.bin_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("bin_out", longint'(bus.bin_out), longint'(mon_e.bin));
        check("err", longint'(bus.err), longint'(mon_e.err));
        $display("txn: bin_out=%0d err=%0d", bus.bin_out, bus.err);
      end
    end
  end

  // Issue one start, count edges (including the accepting edge) until done, and cycles with busy high.
  task automatic run_one(input logic [BCD_W-1:0] bcd, input bit keep, input string name);
    int   n;
    int   busy_n;
    exp_t r;
    n      = 0;
    busy_n = 0;
    r      = ref_model(bcd);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    exp_q.push_back(r);
    while (1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!keep) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done || n >= 40) break;
    end
    check({name, "_latency"}, n, r.err ? 1 : BIN_W + 1);
    check({name, "_busy_cycles"}, busy_n, r.err ? 0 : BIN_W);
  endtask

  initial begin
    int               n;
    logic [BCD_W-1:0] bcd;
    exp_t             r;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_err", bus.err, 0);
    check("reset_bin_out", bus.bin_out, 0);
    reset = 1'b0;
    @(negedge clk);

    run_one(12'h999, 1'b0, "max_999");

    run_one(12'h000, 1'b1, "b2b_000");
    run_one(12'h255, 1'b1, "b2b_255");
    run_one(12'h001, 1'b0, "b2b_001");
    repeat (2) @(negedge clk);

    run_one(12'h1A3, 1'b0, "bad_tens");
    repeat (3) @(negedge clk);
    check("err_held", bus.err, 1);

    // Second start mid-conversion must be ignored.
    bus.start  = 1'b1;
    bus.bcd_in = 12'h512;
    exp_q.push_back(ref_model(12'h512));
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    bus.start  = 1'b1;
    bus.bcd_in = 12'h777;
    @(posedge clk); @(negedge clk);
    bus.start  = 1'b0;
    bus.bcd_in = 12'h000;
    n = 0;
    while (!bus.done && n < 40) begin @(posedge clk); @(negedge clk); n++; end
    check("ignored_start_done", bus.done, 1);
    repeat (15) @(negedge clk);
    check("ignored_start_queue", exp_q.size(), 0);

    // Asynchronous reset mid-conversion discards the result.
    bus.start  = 1'b1;
    bus.bcd_in = 12'h640;
    exp_q.push_back(ref_model(12'h640));
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_done", bus.done, 0);
    check("async_rst_err", bus.err, 0);
    check("async_rst_bin_out", bus.bin_out, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_busy", bus.busy, 0);
    run_one(12'h640, 1'b0, "after_rst_640");

    for (int i = 0; i < 60; i++) begin
      bcd = BCD_W'($urandom_range(0, 4095));
      run_one(bcd, 1'b0, "random");
    end

    for (int i = 0; i < 1000; i++) begin
      bcd = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      run_one(bcd, 1'b0, "sweep");
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: got no finish expected finish before 3ms");
    $fatal(1);
  end

endmodule
